// File: rtl/iq_tap_line.sv
// iq_tap_line: multi-channel decimating tap delay line for the IQ demodulator.
// Every decim_ratio-th valid sample set is pushed into a DEPTH-deep history
// per channel, and all taps are presented in parallel.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   decim_ratio  decimation ratio R (0 -> 1, > DECIM_MAX -> DECIM_MAX)
//   in_valid     in_data carries a new sample set this cycle
//   in_data      channel c at [c*DATA_W +: DATA_W]
//   flush        synchronous clear of taps, phase and fill
//   taps         channel c, tap k at [(c*DEPTH+k)*DATA_W +: DATA_W], k=0 newest
//   shift_pulse  high for the cycle after the taps shifted
//   phase        accepted-sample count within the current decimation period
//   fill_count   taps loaded since reset/flush, saturating at DEPTH
//   full         fill_count == DEPTH
module iq_tap_line #(
    parameter int DATA_W    = 5,
    parameter int DEPTH     = 20,
    parameter int NCH       = 2,
    parameter int DECIM_MAX = 8,
    parameter int PH_W      = $clog2(DECIM_MAX),
    parameter int FC_W      = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [PH_W:0]               decim_ratio,
    input  logic                        in_valid,
    input  logic [NCH*DATA_W-1:0]       in_data,
    input  logic                        flush,
    output logic [NCH*DEPTH*DATA_W-1:0] taps,
    output logic                        shift_pulse,
    output logic [PH_W-1:0]             phase,
    output logic [FC_W-1:0]             fill_count,
    output logic                        full
);

    localparam logic [PH_W:0]   RE_ONE   = (PH_W + 1)'(1);
    localparam logic [PH_W:0]   RE_MAX   = (PH_W + 1)'(DECIM_MAX);
    localparam logic [FC_W-1:0] FILL_MAX = FC_W'(DEPTH);
    localparam logic [FC_W-1:0] FILL_ONE = FC_W'(1);
    localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);

    logic [DATA_W-1:0] taps_q [NCH][DEPTH];
    logic [DATA_W-1:0] taps_d [NCH][DEPTH];
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [FC_W-1:0]   fill_q, fill_d;
    logic              full_q, full_d;
    logic              pulse_q, pulse_d;

    logic [PH_W:0]     re_eff;
    logic [PH_W:0]     re_last;
    logic              period_end;
    logic              shift_evt;

    // Clamp the runtime ratio into 1..DECIM_MAX.
    always_comb begin
        re_eff = decim_ratio;
        if (decim_ratio == '0) begin
            re_eff = RE_ONE;
        end else if (decim_ratio > RE_MAX) begin
            re_eff = RE_MAX;
        end
    end

    // ">=" rather than "==": a ratio lowered below the current phase
    // closes the period on the very next accepted sample.
    assign re_last    = re_eff - RE_ONE;
    assign period_end = ({1'b0, phase_q} >= re_last);
    assign shift_evt  = in_valid && !flush && period_end;

    always_comb begin
        taps_d = taps_q;
        if (flush) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    taps_d[c][k] = '0;
                end
            end
        end else if (shift_evt) begin
            for (int c = 0; c < NCH; c++) begin
                taps_d[c][0] = in_data[c*DATA_W +: DATA_W];
                for (int k = 1; k < DEPTH; k++) begin
                    taps_d[c][k] = taps_q[c][k-1];
                end
            end
        end
    end

    always_comb begin
        phase_d = phase_q;
        fill_d  = fill_q;
        pulse_d = 1'b0;
        if (flush) begin
            phase_d = '0;
            fill_d  = '0;
        end else if (in_valid) begin
            if (period_end) begin
                phase_d = '0;
                pulse_d = 1'b1;
                if (fill_q != FILL_MAX) begin
                    fill_d = fill_q + FILL_ONE;
                end
            end else begin
                phase_d = phase_q + PH_ONE;
            end
        end
    end

    // full is registered from the next fill value so it rises together
    // with fill_count reaching DEPTH.
    assign full_d = (fill_d == FILL_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    taps_q[c][k] <= '0;
                end
            end
            phase_q <= '0;
            fill_q  <= '0;
            full_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            taps_q  <= taps_d;
            phase_q <= phase_d;
            fill_q  <= fill_d;
            full_q  <= full_d;
            pulse_q <= pulse_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        for (genvar k = 0; k < DEPTH; k++) begin : g_tap
            assign taps[(c*DEPTH+k)*DATA_W +: DATA_W] = taps_q[c][k];
        end
    end

    assign shift_pulse = pulse_q;
    assign phase       = phase_q;
    assign fill_count  = fill_q;
    assign full        = full_q;

endmodule

// File: tb/tb_iq_tap_line.sv
// tb_iq_tap_line: directed bench for iq_tap_line with a queue-based
// history model compared every cycle plus literal spot checks.
module tb_iq_tap_line;

    localparam int DATA_W    = 5;
    localparam int DEPTH     = 20;
    localparam int NCH       = 2;
    localparam int DECIM_MAX = 8;
    localparam int PH_W      = 3;
    localparam int FC_W      = 5;
    localparam int SW        = NCH * DATA_W;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [PH_W:0]               decim_ratio;
    logic                        in_valid;
    logic [SW-1:0]               in_data;
    logic                        flush;
    logic [NCH*DEPTH*DATA_W-1:0] taps;
    logic                        shift_pulse;
    logic [PH_W-1:0]             phase;
    logic [FC_W-1:0]             fill_count;
    logic                        full;

    iq_tap_line #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NCH(NCH), .DECIM_MAX(DECIM_MAX)
    ) dut (
        .clk(clk), .reset(reset), .decim_ratio(decim_ratio),
        .in_valid(in_valid), .in_data(in_data), .flush(flush),
        .taps(taps), .shift_pulse(shift_pulse), .phase(phase),
        .fill_count(fill_count), .full(full)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int sp_cnt = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int eff(input int r);
        if (r < 1) return 1;
        if (r > DECIM_MAX) return DECIM_MAX;
        return r;
    endfunction

    // Sample set n: I = n mod 32, Q = 31 - (n mod 32).
    function automatic logic [SW-1:0] mk(input int n);
        logic [4:0] i;
        logic [4:0] q;
        i = n[4:0];
        q = 5'd31 - i;
        return {q, i};
    endfunction

    function automatic int tapv(input int c, input int k);
        return int'(taps[(c*DEPTH+k)*DATA_W +: DATA_W]);
    endfunction

    // Model: history of retained sample sets, newest first.
    logic [SW-1:0] hist[$];
    int  mph = 0;
    bit  msp = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset || flush) begin
            hist.delete();
            mph = 0;
            msp = 1'b0;
        end else if (in_valid) begin
            if (mph + 1 >= eff(int'(decim_ratio))) begin
                hist.push_front(in_data);
                if (hist.size() > DEPTH) void'(hist.pop_back());
                mph = 0;
                msp = 1'b1;
            end else begin
                mph++;
                msp = 1'b0;
            end
        end else begin
            msp = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("phase", int'(phase), mph);
            check("fill_count", int'(fill_count), hist.size());
            check("full", int'(full), int'(hist.size() == DEPTH));
            check("shift_pulse", int'(shift_pulse), int'(msp));
            for (int k = 0; k < DEPTH; k++) begin
                logic [SW-1:0] s;
                s = (k < hist.size()) ? hist[k] : '0;
                for (int c = 0; c < NCH; c++) begin
                    check($sformatf("tap_c%0d_k%0d", c, k), tapv(c, k),
                          int'(s[c*DATA_W +: DATA_W]));
                end
            end
            if (shift_pulse) sp_cnt++;
        end
    end

    task automatic drive(input logic v, input logic [SW-1:0] d, input logic f);
        in_valid = v;
        in_data  = d;
        flush    = f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        decim_ratio = 4'd5;
        in_valid = 1'b0;
        in_data = '0;
        flush = 1'b0;
        #12;
        check("rst_fill", int'(fill_count), 0);
        check("rst_full", int'(full), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_pulse", int'(shift_pulse), 0);
        check("rst_taps_nz", int'(taps != '0), 0);
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        // Re=5, 100 consecutive samples
        sp_cnt = 0;
        for (int n = 0; n < 100; n++) drive(1'b1, mk(n), 1'b0);
        drive(1'b0, '0, 1'b0);
        check("t1_pulses", sp_cnt, 20);
        check("t1_fill", int'(fill_count), 20);
        check("t1_full", int'(full), 1);
        check("t1_tap0_i", tapv(0, 0), 3);
        check("t1_tap0_q", tapv(1, 0), 28);
        check("t1_tap19_i", tapv(0, 19), 4);
        check("t1_tap19_q", tapv(1, 19), 27);

        // Re=3 with alternating valid
        drive(1'b0, '0, 1'b1);
        decim_ratio = 4'd3;
        for (int i = 0; i < 12; i++) drive(i % 2 == 0, mk(i), 1'b0);
        check("t2_fill", int'(fill_count), 2);
        check("t2_phase", int'(phase), 0);
        check("t2_tap0_i", tapv(0, 0), 10);
        check("t2_tap1_i", tapv(0, 1), 4);

        // ratio lowered mid-period, then ratio 0
        drive(1'b0, '0, 1'b1);
        decim_ratio = 4'd8;
        for (int i = 0; i < 6; i++) drive(1'b1, mk(40 + i), 1'b0);
        check("t3_phase6", int'(phase), 6);
        decim_ratio = 4'd4;
        drive(1'b1, mk(50), 1'b0);
        check("t3_pulse", int'(shift_pulse), 1);
        check("t3_phase0", int'(phase), 0);
        check("t3_tap0_i", tapv(0, 0), 18);
        for (int i = 0; i < 3; i++) drive(1'b1, mk(51 + i), 1'b0);
        check("t3_phase3", int'(phase), 3);
        drive(1'b1, mk(54), 1'b0);
        check("t3_pulse4", int'(shift_pulse), 1);
        decim_ratio = 4'd0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, mk(60 + i), 1'b0);
            check("t3_r0_pulse", int'(shift_pulse), 1);
        end
        check("t3_fill", int'(fill_count), 5);
        decim_ratio = 4'd15;
        for (int i = 0; i < 8; i++) drive(1'b1, mk(70 + i), 1'b0);
        check("t3_clamp_fill", int'(fill_count), 6);

        // flush with coincident valid at a shift point
        decim_ratio = 4'd2;
        drive(1'b1, mk(5), 1'b0);
        drive(1'b1, mk(7), 1'b1);
        check("t4_fill", int'(fill_count), 0);
        check("t4_full", int'(full), 0);
        check("t4_phase", int'(phase), 0);
        check("t4_taps_nz", int'(taps != '0), 0);
        decim_ratio = 4'd1;
        for (int i = 1; i <= 3; i++) drive(1'b1, mk(i), 1'b0);
        check("t4_fill3", int'(fill_count), 3);
        check("t4_tap0_i", tapv(0, 0), 3);

        // asynchronous reset mid-cycle
        for (int i = 0; i < 22; i++) drive(1'b1, mk(80 + i), 1'b0);
        check("t5_pre_full", int'(full), 1);
        #3;
        reset = 1'b0;
        #1;
        check("t5_fill", int'(fill_count), 0);
        check("t5_full", int'(full), 0);
        check("t5_phase", int'(phase), 0);
        check("t5_taps_nz", int'(taps != '0), 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        drive(1'b1, mk(17), 1'b0);
        check("t5_tap0_i", tapv(0, 0), 17);
        check("t5_tap0_q", tapv(1, 0), 14);
        check("t5_fill1", int'(fill_count), 1);

        // saturation with Re=1
        drive(1'b0, '0, 1'b1);
        decim_ratio = 4'd1;
        for (int n = 0; n < 50; n++) drive(1'b1, mk(n), 1'b0);
        check("t6_fill", int'(fill_count), 20);
        check("t6_full", int'(full), 1);
        for (int k = 0; k < DEPTH; k++) begin
            check($sformatf("t6_tap%0d_i", k), tapv(0, k), (49 - k) % 32);
            check($sformatf("t6_tap%0d_q", k), tapv(1, k), 31 - (49 - k) % 32);
        end
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
